// File: rtl/seg_if.sv
// Segment-pattern bus between a pattern source and the sequence tracker.
interface seg_if;
  logic       seg_valid;
  logic [6:0] seg;
  logic [3:0] digit;
  logic       digit_valid;
  logic [3:0] pos;
  logic [1:0] dir;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  modport master (
    output seg_valid, seg,
    input  digit, digit_valid, pos, dir, locked, err, err_count
  );

  modport slave (
    input  seg_valid, seg,
    output digit, digit_valid, pos, dir, locked, err, err_count
  );
endinterface

// File: rtl/seg_sequence_tracker.sv
// Decodes sampled 7-segment patterns and tracks position in the display sequence
// 2,8,3,4,5,4,1,0,7, inferring hold/down/up/blank mode, lock and errors.
module seg_sequence_tracker #(
  parameter int unsigned LOCK_COUNT     = 3,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  seg_if.slave  bus
);

  localparam int unsigned POS_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [3:0]       SYM_BLANK = 4'hE;
  localparam logic [3:0]       SYM_BAD   = 4'hF;
  localparam logic [3:0]       SYM_NONE  = 4'hD;
  localparam logic [POS_W-1:0] POS_NONE  = 4'd9;
  localparam logic [POS_W-1:0] POS_LAST  = 4'd8;
  localparam logic [1:0]       DIR_HOLD  = 2'b00;
  localparam logic [1:0]       DIR_DOWN  = 2'b01;
  localparam logic [1:0]       DIR_UP    = 2'b10;
  localparam logic [1:0]       DIR_BLANK = 2'b11;

  typedef enum logic [1:0] {ACQ, SYNC, LOCK, BLANK} state_t;
  typedef enum logic [1:0] {STEP_HOLD, STEP_UP, STEP_DOWN, STEP_NONE} step_t;

  function automatic logic [3:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = 4'd0;
      7'b1001111: decode = 4'd1;
      7'b0010010: decode = 4'd2;
      7'b0000110: decode = 4'd3;
      7'b1001100: decode = 4'd4;
      7'b0100100: decode = 4'd5;
      7'b0100000: decode = 4'd6;
      7'b0001111: decode = 4'd7;
      7'b0000000: decode = 4'd8;
      7'b0000100: decode = 4'd9;
      7'b1111111: decode = SYM_BLANK;
      default:    decode = SYM_BAD;
    endcase
  endfunction

  function automatic logic [3:0] seq_at(input logic [POS_W-1:0] i);
    case (i)
      4'd0:    seq_at = 4'd2;
      4'd1:    seq_at = 4'd8;
      4'd2:    seq_at = 4'd3;
      4'd3:    seq_at = 4'd4;
      4'd4:    seq_at = 4'd5;
      4'd5:    seq_at = 4'd4;
      4'd6:    seq_at = 4'd1;
      4'd7:    seq_at = 4'd0;
      4'd8:    seq_at = 4'd7;
      default: seq_at = SYM_NONE;
    endcase
  endfunction

  // Unique index for every sequence digit except the ambiguous 4.
  function automatic logic [POS_W-1:0] seq_index(input logic [3:0] s);
    case (s)
      4'd2:    seq_index = 4'd0;
      4'd8:    seq_index = 4'd1;
      4'd3:    seq_index = 4'd2;
      4'd5:    seq_index = 4'd4;
      4'd1:    seq_index = 4'd6;
      4'd0:    seq_index = 4'd7;
      4'd7:    seq_index = 4'd8;
      default: seq_index = POS_NONE;
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [3:0]       digit_q;
  logic             digit_valid_q;
  logic [POS_W-1:0] pos_q, pos_nxt;
  logic [1:0]       dir_q, dir_nxt;
  logic             locked_q;
  logic             err_q, err_nxt;
  logic [CNT_W-1:0] err_count_q;
  logic [3:0]       good_q, good_nxt;

  logic [3:0]       sym_c;
  logic [POS_W-1:0] pos_up_c, pos_dn_c, acq_idx_c;
  logic [3:0]       good_inc_c;
  logic             is_blank_c;
  step_t            step_c;

  // Symbol decode and step classification against the current position.
  always_comb begin
    sym_c      = decode(SEG_ACTIVE_LOW ? bus.seg : ~bus.seg);
    is_blank_c = (sym_c == SYM_BLANK);
    acq_idx_c  = seq_index(sym_c);
    pos_up_c   = (pos_q >= POS_LAST) ? '0 : POS_W'(pos_q + POS_W'(1));
    pos_dn_c   = (pos_q == '0) ? POS_LAST : POS_W'(pos_q - POS_W'(1));
    good_inc_c = 4'(good_q + 4'd1);
    step_c     = STEP_NONE;
    if (sym_c == seq_at(pos_q))
      step_c = STEP_HOLD;
    else if (sym_c == seq_at(pos_up_c) && sym_c == seq_at(pos_dn_c))
      step_c = (dir_q == DIR_DOWN) ? STEP_DOWN : STEP_UP;
    else if (sym_c == seq_at(pos_up_c))
      step_c = STEP_UP;
    else if (sym_c == seq_at(pos_dn_c))
      step_c = STEP_DOWN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.seg_valid) begin
      case (state)
        ACQ: begin
          if (is_blank_c)                  state_nxt = BLANK;
          else if (acq_idx_c != POS_NONE)  state_nxt = SYNC;
        end
        SYNC, LOCK: begin
          if (step_c != STEP_NONE) begin
            if (state == SYNC && good_inc_c == 4'(LOCK_COUNT)) state_nxt = LOCK;
          end
          else if (is_blank_c) state_nxt = BLANK;
          else                 state_nxt = ACQ;
        end
        BLANK: begin
          if (is_blank_c)           state_nxt = BLANK;
          else if (sym_c == 4'd2)   state_nxt = SYNC;
          else                      state_nxt = ACQ;
        end
        default: state_nxt = ACQ;
      endcase
    end
  end

  always_comb begin
    pos_nxt  = pos_q;
    dir_nxt  = dir_q;
    good_nxt = good_q;
    err_nxt  = 1'b0;
    if (bus.seg_valid) begin
      case (state)
        ACQ: begin
          if (is_blank_c) begin
            pos_nxt = POS_NONE;
            dir_nxt = DIR_BLANK;
          end else if (acq_idx_c != POS_NONE) begin
            pos_nxt  = acq_idx_c;
            dir_nxt  = DIR_HOLD;
            good_nxt = '0;
          end else begin
            pos_nxt = POS_NONE;
            dir_nxt = DIR_HOLD;
            err_nxt = (sym_c != 4'd4);
          end
        end
        SYNC, LOCK: begin
          if (step_c != STEP_NONE && state == SYNC) good_nxt = good_inc_c;
          case (step_c)
            STEP_HOLD: dir_nxt = DIR_HOLD;
            STEP_UP: begin
              pos_nxt = pos_up_c;
              dir_nxt = DIR_UP;
            end
            STEP_DOWN: begin
              pos_nxt = pos_dn_c;
              dir_nxt = DIR_DOWN;
            end
            default: begin
              pos_nxt = POS_NONE;
              if (is_blank_c) begin
                dir_nxt = DIR_BLANK;
              end else begin
                dir_nxt = DIR_HOLD;
                err_nxt = 1'b1;
              end
            end
          endcase
        end
        BLANK: begin
          if (is_blank_c) begin
            pos_nxt = POS_NONE;
            dir_nxt = DIR_BLANK;
          end else if (sym_c == 4'd2) begin
            pos_nxt  = '0;
            dir_nxt  = DIR_UP;
            good_nxt = '0;
          end else begin
            pos_nxt = POS_NONE;
            dir_nxt = DIR_HOLD;
            err_nxt = 1'b1;
          end
        end
        default: begin
          pos_nxt = POS_NONE;
          dir_nxt = DIR_HOLD;
        end
      endcase
    end
  end

  // Registered outputs; everything except the pulses holds between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q       <= SYM_BAD;
      digit_valid_q <= 1'b0;
      pos_q         <= POS_NONE;
      dir_q         <= DIR_HOLD;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
      good_q        <= '0;
    end else begin
      digit_valid_q <= bus.seg_valid;
      err_q         <= err_nxt;
      if (bus.seg_valid) digit_q <= sym_c;
      pos_q    <= pos_nxt;
      dir_q    <= dir_nxt;
      good_q   <= good_nxt;
      locked_q <= (state_nxt == LOCK);
      if (err_nxt && err_count_q != '1) err_count_q <= CNT_W'(err_count_q + CNT_W'(1));
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.pos         = pos_q;
  assign bus.dir         = dir_q;
  assign bus.locked      = locked_q;
  assign bus.err         = err_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_seg_sequence_tracker.sv
// Directed bench for seg_sequence_tracker: acquisition, up/down/hold steps, blank,
// ambiguity at digit 4, errors and asynchronous reset.
module tb_seg_sequence_tracker;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SX = 7'b1010101;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  seg_if bus();

  seg_sequence_tracker #(.LOCK_COUNT(3), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
  endtask

  // One strobe, then sample at the following falling edge.
  task automatic send(input logic [6:0] p);
    @(negedge clk);
    bus.seg_valid = 1'b1;
    bus.seg       = p;
    @(negedge clk);
    bus.seg_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] d, input logic [3:0] p,
                            input logic [1:0] dr, input logic lk, input logic e,
                            input logic [7:0] cnt);
    check({tag, ".valid"},  8'(bus.digit_valid), 8'd1);
    check({tag, ".digit"},  8'(bus.digit),       8'(d));
    check({tag, ".pos"},    8'(bus.pos),         8'(p));
    check({tag, ".dir"},    8'(bus.dir),         8'(dr));
    check({tag, ".locked"}, 8'(bus.locked),      8'(lk));
    check({tag, ".err"},    8'(bus.err),         8'(e));
    check({tag, ".errcnt"}, bus.err_count,       cnt);
  endtask

  initial begin
    rst           = 1'b1;
    bus.seg_valid = 1'b0;
    bus.seg       = S8;

    // Reset held while the pattern source is active
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.seg_valid = ~bus.seg_valid;
      bus.seg       = (i % 2 == 0) ? S2 : S8;
      @(posedge clk);
      #1;
      check("rst.valid", 8'(bus.digit_valid), 8'd0);
    end
    check("rst.digit",  8'(bus.digit),  8'h0F);
    check("rst.pos",    8'(bus.pos),    8'd9);
    check("rst.dir",    8'(bus.dir),    8'd0);
    check("rst.locked", 8'(bus.locked), 8'd0);
    check("rst.err",    8'(bus.err),    8'd0);
    check("rst.errcnt", bus.err_count,  8'd0);
    @(negedge clk);
    bus.seg_valid = 1'b0;
    rst = 1'b0;

    // Acquire and lock walking up
    send(S2); expect_out("acq2",  4'd2, 4'd0, 2'b00, 1'b0, 1'b0, 8'd0);
    send(S8); expect_out("up8",   4'd8, 4'd1, 2'b10, 1'b0, 1'b0, 8'd0);
    send(S3); expect_out("up3",   4'd3, 4'd2, 2'b10, 1'b0, 1'b0, 8'd0);
    send(S4); expect_out("lock4", 4'd4, 4'd3, 2'b10, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    check("idle.valid",  8'(bus.digit_valid), 8'd0);
    check("idle.pos",    8'(bus.pos),         8'd3);
    check("idle.locked", 8'(bus.locked),      8'd1);

    // Digit 4 ambiguity resolved by last direction
    send(S5); expect_out("up5",     4'd5, 4'd4, 2'b10, 1'b1, 1'b0, 8'd0);
    send(S4); expect_out("amb_up",  4'd4, 4'd5, 2'b10, 1'b1, 1'b0, 8'd0);
    send(S5); expect_out("dn5",     4'd5, 4'd4, 2'b01, 1'b1, 1'b0, 8'd0);
    send(S4); expect_out("amb_dn",  4'd4, 4'd3, 2'b01, 1'b1, 1'b0, 8'd0);

    // Walk down through index 0 and wrap to 8
    send(S3); expect_out("dn3",   4'd3, 4'd2, 2'b01, 1'b1, 1'b0, 8'd0);
    send(S8); expect_out("dn8",   4'd8, 4'd1, 2'b01, 1'b1, 1'b0, 8'd0);
    send(S2); expect_out("dn2",   4'd2, 4'd0, 2'b01, 1'b1, 1'b0, 8'd0);
    send(S7); expect_out("wrap7", 4'd7, 4'd8, 2'b01, 1'b1, 1'b0, 8'd0);
    send(S0); expect_out("dn0",   4'd0, 4'd7, 2'b01, 1'b1, 1'b0, 8'd0);
    send(S0); expect_out("hold0", 4'd0, 4'd7, 2'b00, 1'b1, 1'b0, 8'd0);

    // Blank, leave blank at index 0, then an off-sequence digit
    send(SB); expect_out("blank",  4'hE, 4'd9, 2'b11, 1'b0, 1'b0, 8'd0);
    send(S2); expect_out("unbl2",  4'd2, 4'd0, 2'b10, 1'b0, 1'b0, 8'd0);
    send(S6); expect_out("err6",   4'd6, 4'd9, 2'b00, 1'b0, 1'b1, 8'd1);
    @(negedge clk);
    check("errpulse.err",   8'(bus.err),         8'd0);
    check("errpulse.valid", 8'(bus.digit_valid), 8'd0);

    // ACQ handling of 4, 9 and an undecodable pattern
    send(S4); expect_out("acq4",   4'd4, 4'd9, 2'b00, 1'b0, 1'b0, 8'd1);
    send(S9); expect_out("acq9",   4'd9, 4'd9, 2'b00, 1'b0, 1'b1, 8'd2);
    send(S7); expect_out("acq7",   4'd7, 4'd8, 2'b00, 1'b0, 1'b0, 8'd2);
    send(SX); expect_out("badpat", 4'hF, 4'd9, 2'b00, 1'b0, 1'b1, 8'd3);

    // Relock, break it with a jump, relock again
    send(S2); send(S8); send(S3);
    send(S4); expect_out("relock1", 4'd4, 4'd3, 2'b10, 1'b1, 1'b0, 8'd3);
    send(S1); expect_out("jump1",   4'd1, 4'd9, 2'b00, 1'b0, 1'b1, 8'd4);
    send(S2); send(S8); send(S3);
    send(S4); expect_out("relock2", 4'd4, 4'd3, 2'b10, 1'b1, 1'b0, 8'd4);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.locked", 8'(bus.locked), 8'd0);
    check("arst.pos",    8'(bus.pos),    8'd9);
    check("arst.errcnt", bus.err_count,  8'd0);
    check("arst.digit",  8'(bus.digit),  8'h0F);
    @(negedge clk);
    rst = 1'b0;
    send(S2); expect_out("post", 4'd2, 4'd0, 2'b00, 1'b0, 1'b0, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
